// File: rtl/delay_line_ctrl_pkg.sv
// Shared state encoding and default widths for the operand delay-line sequencer.
package definition;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 2;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dlc_state_e;

  // Width of one pipe stage: {valid, last, data}.
  function automatic int beat_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/delay_line_ctrl_delay_pipe.sv
// Fixed-depth register chain carrying {valid, last, data}; advances every cycle.
module delay_pipe #(
  parameter int W     = 18,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] i_beat,
  output logic [W-1:0] o_beat,
  output logic         o_any_valid
);

  logic [W-1:0] r_stage [DEPTH];
  logic         w_any_valid;

  // Shift chain: stage 0 takes the new beat, every other stage takes its predecessor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= {W{1'b0}};
      end
    end else begin
      r_stage[0] <= i_beat;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // Valid beats that will still be inside the pipe after the next edge (output stage excluded).
  always_comb begin
    w_any_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_any_valid = w_any_valid | r_stage[i][W-1];
    end
  end

  assign o_beat      = r_stage[DEPTH-1];
  assign o_any_valid = w_any_valid;

endmodule

// File: rtl/delay_line_ctrl.sv
// Burst sequencer: accepts cfg_len beats, pushes them through a DEPTH-stage
// delay pipe, tags the final beat and pulses done once the pipe has drained.
module delay_line_ctrl
  import definition::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int BEAT_W = beat_w(DATA_W);

  dlc_state_e        r_state;
  dlc_state_e        w_state_nxt;
  logic [LEN_W-1:0]  r_len_q;
  logic [LEN_W-1:0]  r_cnt;
  logic              w_accept;
  logic              w_is_last;
  logic              w_any_valid;
  logic [BEAT_W-1:0] w_pipe_in;
  logic [BEAT_W-1:0] w_pipe_out;

  assign in_ready  = (r_state == LOAD);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_is_last = (r_cnt == (r_len_q - LEN_W'(1'b1)));

  // Data is gated to zero on bubbles so in_data is never captured unless accepted.
  assign w_pipe_in = {w_accept, w_accept && w_is_last,
                      (w_accept ? in_data : {DATA_W{1'b0}})};

  // Next-state decision for the burst sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (cfg_len != {LEN_W{1'b0}}) ? LOAD : DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (w_accept && w_is_last) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      DRAIN: begin
        if (!w_any_valid) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, captured burst length and accepted-beat counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_len_q <= {LEN_W{1'b0}};
      r_cnt   <= {LEN_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_len_q <= cfg_len;
        r_cnt   <= {LEN_W{1'b0}};
      end else if (w_accept) begin
        r_cnt   <= r_cnt + LEN_W'(1'b1);
      end
    end
  end

  delay_pipe #(
    .W     (BEAT_W),
    .DEPTH (DEPTH)
  ) u_delay_pipe (
    .clk         (clk),
    .rstn        (rstn),
    .i_beat      (w_pipe_in),
    .o_beat      (w_pipe_out),
    .o_any_valid (w_any_valid)
  );

  assign out_valid = w_pipe_out[BEAT_W-1];
  assign out_last  = w_pipe_out[BEAT_W-2];
  assign out_data  = w_pipe_out[DATA_W-1:0];

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed + randomized bench for delay_line_ctrl against a cycle-scheduled reference model.
module tb_delay_line_ctrl;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: burst bookkeeping plus a schedule of expected output beats keyed by cycle.
  bit              m_active  = 1'b0;
  bit              m_loading = 1'b0;
  int              m_len     = 0;
  int              m_acc     = 0;
  int              m_done_cyc = -1;
  bit              exp_l [int];
  logic [DATA_W-1:0] exp_d [int];

  delay_line_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model at the rising edge.
  task automatic step(input logic st, input logic [LEN_W-1:0] len,
                      input logic iv, input logic [DATA_W-1:0] id);
    logic e_rdy, e_busy, e_done, e_v, e_l;
    logic [DATA_W-1:0] e_d;
    start = st; cfg_len = len; in_valid = iv; in_data = id;
    e_rdy  = m_loading;
    e_busy = m_active;
    e_done = m_active && (cyc == m_done_cyc);
    e_v    = exp_d.exists(cyc);
    e_l    = e_v ? exp_l[cyc] : 1'b0;
    e_d    = e_v ? exp_d[cyc] : '0;
    @(negedge clk);
    chk("in_ready",  in_ready,  e_rdy);
    chk("busy",      busy,      e_busy);
    chk("done",      done,      e_done);
    chk("out_valid", out_valid, e_v);
    chk("out_last",  out_last,  e_l);
    if (e_v) chk("out_data", out_data, e_d);
    if (m_loading && iv) begin
      exp_d[cyc + DEPTH] = id;
      exp_l[cyc + DEPTH] = (m_acc == m_len - 1);
      m_acc++;
      if (m_acc == m_len) begin
        m_loading  = 1'b0;
        m_done_cyc = cyc + DEPTH + 1;
      end
    end
    if (!m_active && st) begin
      m_active = 1'b1;
      m_len    = int'(len);
      m_acc    = 0;
      if (len == '0) m_done_cyc = cyc + 1;
      else begin
        m_loading  = 1'b1;
        m_done_cyc = -1;
      end
    end
    if (e_done) m_active = 1'b0;
    if (e_v) begin
      exp_d.delete(cyc);
      exp_l.delete(cyc);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, DATA_W'($urandom));
  endtask

  task automatic mid_reset();
    start = 1'b0; in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  '0);
    chk("rst_out_last",  out_last,  1'b0);
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_done",      done,      1'b0);
    m_active = 1'b0; m_loading = 1'b0; m_done_cyc = -1;
    exp_d.delete(); exp_l.delete();
    @(posedge clk); #1;
    chk("rst_hold_done", done, 1'b0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int guard;
    rstn = 1'b0; start = 1'b0; cfg_len = '0; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    chk("reset_in_ready",  in_ready,  1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data",  out_data,  '0);
    chk("reset_out_last",  out_last,  1'b0);
    chk("reset_busy",      busy,      1'b0);
    chk("reset_done",      done,      1'b0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    cyc = 0;

    // Contiguous burst of 3.
    step(1'b1, 8'd3, 1'b0, 16'h0);
    step(1'b0, 8'd0, 1'b1, 16'd1);
    step(1'b0, 8'd0, 1'b1, 16'd2);
    step(1'b0, 8'd0, 1'b1, 16'd3);
    idle(5);

    // Burst of 2 with a bubble in the middle.
    step(1'b1, 8'd2, 1'b0, 16'h0);
    step(1'b0, 8'd0, 1'b1, 16'd4);
    step(1'b0, 8'd0, 1'b0, 16'hdead);
    step(1'b0, 8'd0, 1'b1, 16'd5);
    idle(5);

    // Zero-length burst.
    step(1'b1, 8'd0, 1'b1, 16'h1111);
    step(1'b0, 8'd0, 1'b1, 16'h2222);
    idle(3);

    // Start pulse with a different length while a 3-beat burst is loading.
    step(1'b1, 8'd3, 1'b0, 16'h0);
    step(1'b0, 8'd0, 1'b1, 16'h00a1);
    step(1'b1, 8'd9, 1'b1, 16'h00a2);
    step(1'b0, 8'd0, 1'b1, 16'h00a3);
    for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b1, 16'h0bad);

    // Reset with one beat in the pipe, then a fresh contiguous burst.
    step(1'b1, 8'd3, 1'b0, 16'h0);
    step(1'b0, 8'd0, 1'b1, 16'h0077);
    mid_reset();
    idle(2);
    step(1'b1, 8'd3, 1'b0, 16'h0);
    step(1'b0, 8'd0, 1'b1, 16'd1);
    step(1'b0, 8'd0, 1'b1, 16'd2);
    step(1'b0, 8'd0, 1'b1, 16'd3);
    idle(5);

    // Maximum-length continuous burst.
    step(1'b1, 8'd255, 1'b0, 16'h0);
    for (int i = 0; i < 255; i++) step(1'b0, 8'd0, 1'b1, DATA_W'($urandom));
    idle(5);

    // Randomized bursts with random bubbles and stray start pulses.
    for (int b = 0; b < 8; b++) begin
      step(1'b1, LEN_W'($urandom_range(1, 12)), 1'b0, DATA_W'($urandom));
      guard = 0;
      while (m_active && guard < 300) begin
        step(($urandom_range(0, 7) == 0), LEN_W'($urandom), ($urandom_range(0, 3) != 0),
             DATA_W'($urandom));
        guard++;
      end
      chk("burst_ends", busy, 1'b0);
      idle($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Sequencer for the fixed-depth register delay lines used to skew operand streams into the compute array. It accepts a burst of `cfg_len` data beats over a valid/ready handshake and pushes them through a `DEPTH`-stage delay pipe. It tags the final beat, drains the pipe, and reports completion with a one-cycle `done` pulse. It sits between the on-chip operand buffer read port and the array edge registers.

## Interface
- `DATA_W`, 16, width of one data beat
- `DEPTH`, 2, number of register stages in the delay line (≥1)
- `LEN_W`, 8, width of the burst-length field
- `clk`  in  1  clock; all state updates on the rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `start`  in  1  launch a burst; sampled only in IDLE
- `cfg_len`  in  LEN_W  beats in the burst; captured when `start` is accepted
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  controller accepts a beat this cycle
- `in_data`  in  DATA_W  upstream beat
- `out_valid`  out  1  delayed beat valid
- `out_data`  out  DATA_W  delayed beat
- `out_last`  out  1  delayed beat is the final beat of the burst
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE: `start`=1 captures `cfg_len` into `len_q` and clears `cnt`. Next state is LOAD if `cfg_len`≠0, else DONE.
- LOAD: `in_ready`=1. A beat is accepted when `in_valid && in_ready`. An accepted beat enters pipe stage 0 with valid=1 and last=(`cnt`==`len_q`−1), then `cnt` increments. After the last beat is accepted, next state is DRAIN. Cycles with `in_valid`=0 insert a bubble: stage 0 valid=0.
- DRAIN: `in_ready`=0; bubbles enter stage 0. Next state is DONE when the next-cycle pipe would hold no valid stage, i.e. in the cycle the last beat is on the output.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- The pipe advances every cycle in every state; there is no output back-pressure.
- `start` in any state other than IDLE is ignored; no error is flagged.
- `cnt` is LEN_W bits wide and is compared with `len_q`. No wrap occurs: the maximum burst is 2^LEN_W−1 beats.
- `in_data` is not sampled when `in_ready`=0.

## Timing
- Reset (`rstn`=0, async): state=IDLE, `cnt`=0, `len_q`=0, all pipe valid/last/data=0. Therefore `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- Reset asserted mid-burst clears everything immediately. In-flight beats are discarded and no `done` is produced.
- `start` sampled at edge t → LOAD (`in_ready`=1) from cycle t+1.
- Beat accepted at edge t → `out_valid`/`out_data` registered output in cycle t+DEPTH. Latency is exactly DEPTH.
- Last beat accepted at edge k → out at k+DEPTH with `out_last`=1 → `done`=1 in cycle k+DEPTH+1 → IDLE (`busy`=0) in cycle k+DEPTH+2.
- `cfg_len`=0: `start` at edge t → `done`=1 in cycle t+1 with no output beats → IDLE at t+2.
- A new `start` is accepted from the first IDLE cycle. Back-to-back bursts are separated by at least the DONE cycle.

## Structure
- Shared package `definition`: `dlc_state_e` enum {IDLE, LOAD, DRAIN, DONE} and the default `DATA_W` constant.
- Sub-module `delay_pipe`: DEPTH-stage register chain carrying {valid, last, data}. It has async active-low reset and a single `in` and `out` port. It exposes `any_valid` (OR of stage valids) for the drain decision.
- The controller holds the FSM, `len_q`, `cnt`, and handshake logic only.

## Test plan
Settings for all scenarios: DEPTH=2, DATA_W=16, clock period 20 ns.
- **Contiguous burst:** `cfg_len`=3; `start` at cycle 0; `in_valid`=1 with data 1, 2, 3 in cycles 1–3 → `out_data` 1, 2, 3 in cycles 3–5, `out_last` only in cycle 5, `done` in cycle 6, `busy`=0 in cycle 7.
- **Bubbles:** `cfg_len`=2; data 4 in cycle 1, `in_valid`=0 in cycle 2, data 5 in cycle 3 → outputs in cycles 3 and 5, `out_valid`=0 in cycle 4, `done` in cycle 6.
- **Zero length:** `cfg_len`=0 with `start` → `done` one cycle later; `out_valid` never asserts; `in_ready` stays 0.
- **Start while busy:** pulse `start` with `cfg_len`=9 during LOAD of a 3-beat burst → the burst still ends after 3 beats and `len_q` is unchanged.
- **Reset mid-burst:** drop `rstn` while 1 beat is in the pipe → all outputs are 0 at once, no `done` follows, and a fresh burst after release behaves as in the contiguous-burst scenario.
- **Max length:** `cfg_len`=255 continuous → 255 outputs, `out_last` on the 255th only, `done` DEPTH+1 cycles after the final acceptance.
